// File: rtl/reg_bus_writer.sv
// reg_bus_writer
// Writer side of an octal 3-state register with active-low clock enable and
// active-low clear. Commands (write byte / clear) are queued in a small FIFO
// and replayed on the register pins as a setup / strobe / hold sequence, or
// as a clear pulse of fixed length. All pin outputs are registered.
module reg_bus_writer #(
  parameter int DEPTH      = 4,  // command FIFO entries, power of 2, >= 2
  parameter int SETUP      = 1,  // driven cycles before the strobe
  parameter int HOLD       = 1,  // driven cycles after the strobe
  parameter int CLR_CYCLES = 2   // clear pulse length, >= 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_clr,
  input  logic [7:0] cmd_data,
  output logic [7:0] bus_d,
  output logic       bus_oe,
  output logic       reg_en_n,
  output logic       reg_clr_n,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_CLEAR,
    S_DONE
  } state_t;

  // FIFO entry: {clear flag, data byte}
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  state_t        state;
  logic [CW-1:0] cnt;

  // Ready depends only on the stored count (and is held low during reset);
  // a pop in the same cycle does not open a slot early.
  assign cmd_ready = !rst && (count < FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign busy      = (state != S_IDLE) || (count != '0);

  // FIFO storage: data path, written on accepted commands only
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_clr, cmd_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // Command sequencer; pin outputs are set together with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus_d     <= '0;
      bus_oe    <= 1'b0;
      reg_en_n  <= 1'b1;
      reg_clr_n <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (head[8]) begin
              // clear: bus stays released for the whole pulse
              state     <= S_CLEAR;
              cnt       <= CW'(CLR_CYCLES - 1);
              reg_clr_n <= 1'b0;
              bus_oe    <= 1'b0;
              bus_d     <= '0;
            end else if (SETUP > 0) begin
              state  <= S_SETUP;
              cnt    <= CW'(SETUP - 1);
              bus_oe <= 1'b1;
              bus_d  <= head[7:0];
            end else begin
              // no setup time: strobe in the first driven cycle
              state    <= S_STROBE;
              bus_oe   <= 1'b1;
              bus_d    <= head[7:0];
              reg_en_n <= 1'b0;
            end
          end
        end

        S_SETUP: begin
          if (cnt == '0) begin
            state    <= S_STROBE;
            reg_en_n <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_STROBE: begin
          // the register captures on the edge that closes this cycle
          reg_en_n <= 1'b1;
          if (HOLD > 0) begin
            state <= S_HOLD;
            cnt   <= CW'(HOLD - 1);
          end else begin
            state  <= S_DONE;
            bus_oe <= 1'b0;
            bus_d  <= '0;
            done   <= 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            state  <= S_DONE;
            bus_oe <= 1'b0;
            bus_d  <= '0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_CLEAR: begin
          if (cnt == '0) begin
            state     <= S_DONE;
            reg_clr_n <= 1'b1;
            done      <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          bus_oe    <= 1'b0;
          bus_d     <= '0;
          reg_en_n  <= 1'b1;
          reg_clr_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_writer.sv
// Bench for reg_bus_writer: two instances (default timing, and a SETUP=0/HOLD=0
// build) share one stimulus stream. A command-level reference model predicts
// every output each cycle from when each command was accepted and started.
module tb_reg_bus_writer;

  localparam int A_DEPTH = 4, A_SETUP = 1, A_HOLD = 1, A_CLR = 2;
  localparam int B_DEPTH = 2, B_SETUP = 0, B_HOLD = 0, B_CLR = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_clr = 1'b0;
  logic [7:0] cmd_data = 8'h00;

  logic       ready_a, oe_a, en_n_a, clr_n_a, busy_a, done_a;
  logic [7:0] bus_d_a;
  logic       ready_b, oe_b, en_n_b, clr_n_b, busy_b, done_b;
  logic [7:0] bus_d_b;

  always #5 clk = ~clk;

  reg_bus_writer #(.DEPTH(A_DEPTH), .SETUP(A_SETUP), .HOLD(A_HOLD), .CLR_CYCLES(A_CLR)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_a), .cmd_clr(cmd_clr),
    .cmd_data(cmd_data), .bus_d(bus_d_a), .bus_oe(oe_a), .reg_en_n(en_n_a),
    .reg_clr_n(clr_n_a), .busy(busy_a), .done(done_a));

  reg_bus_writer #(.DEPTH(B_DEPTH), .SETUP(B_SETUP), .HOLD(B_HOLD), .CLR_CYCLES(B_CLR)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(ready_b), .cmd_clr(cmd_clr),
    .cmd_data(cmd_data), .bus_d(bus_d_b), .bus_oe(oe_b), .reg_en_n(en_n_b),
    .reg_clr_n(clr_n_b), .busy(busy_b), .done(done_b));

  typedef struct packed {
    logic       clr;
    logic [7:0] data;
  } cmd_t;

  // reference model state, one slot per instance
  cmd_t mq[2][$];
  int   depth[2], setup[2], hold[2], clrc[2];
  int   free_c[2];     // first cycle in which the sequencer is idle again
  int   op_start[2];   // cycle right after the pop edge of the current command
  bit   op_valid[2];
  cmd_t op[2];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bit         rec = 1'b0;
  logic [7:0] seen[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(bit v, bit c, logic [7:0] d);
    cmd_valid = v;
    cmd_clr   = c;
    cmd_data  = d;
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge(int id);
    bit rdy;
    if (rst) begin
      mq[id].delete();
      op_valid[id] = 1'b0;
      free_c[id]   = cyc;
    end else begin
      rdy = (mq[id].size() < depth[id]);
      if (mq[id].size() > 0 && (cyc - 1) >= free_c[id]) begin
        op[id]       = mq[id].pop_front();
        op_valid[id] = 1'b1;
        op_start[id] = cyc;
        if (op[id].clr) free_c[id] = cyc + clrc[id] + 1;
        else            free_c[id] = cyc + setup[id] + hold[id] + 2;
      end
      if (cmd_valid && rdy) mq[id].push_back({cmd_clr, cmd_data});
    end
  endtask

  // Compare every output of one instance with the model's prediction.
  task automatic check_dut(int id);
    logic [7:0] e_d;
    logic e_oe, e_en, e_clr, e_done, e_busy, e_rdy;
    int t;
    string p;
    e_d = 8'h00; e_oe = 1'b0; e_en = 1'b1; e_clr = 1'b1; e_done = 1'b0;
    if (op_valid[id] && cyc >= op_start[id]) begin
      t = cyc - op_start[id];
      if (!op[id].clr) begin
        if (t <= setup[id] + hold[id]) begin
          e_oe = 1'b1;
          e_d  = op[id].data;
          e_en = (t == setup[id]) ? 1'b0 : 1'b1;
        end else if (t == setup[id] + hold[id] + 1) begin
          e_done = 1'b1;
        end
      end else begin
        if (t < clrc[id]) e_clr = 1'b0;
        else if (t == clrc[id]) e_done = 1'b1;
      end
    end
    e_busy = (cyc < free_c[id]) || (mq[id].size() > 0);
    e_rdy  = !rst && (mq[id].size() < depth[id]);
    p = (id == 0) ? "a" : "b";
    if (id == 0) begin
      check({p, ".bus_d"}, bus_d_a, e_d);
      check({p, ".bus_oe"}, oe_a, e_oe);
      check({p, ".reg_en_n"}, en_n_a, e_en);
      check({p, ".reg_clr_n"}, clr_n_a, e_clr);
      check({p, ".done"}, done_a, e_done);
      check({p, ".busy"}, busy_a, e_busy);
      check({p, ".cmd_ready"}, ready_a, e_rdy);
    end else begin
      check({p, ".bus_d"}, bus_d_b, e_d);
      check({p, ".bus_oe"}, oe_b, e_oe);
      check({p, ".reg_en_n"}, en_n_b, e_en);
      check({p, ".reg_clr_n"}, clr_n_b, e_clr);
      check({p, ".done"}, done_b, e_done);
      check({p, ".busy"}, busy_b, e_busy);
      check({p, ".cmd_ready"}, ready_b, e_rdy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    check_dut(0);
    check_dut(1);
    if (rec && en_n_a === 1'b0) seen.push_back(bus_d_a);
  endtask

  initial begin
    logic [7:0] vals[6];
    int   k;
    int   found;
    int   clr_low;
    bit   acc;

    depth = '{A_DEPTH, B_DEPTH};
    setup = '{A_SETUP, B_SETUP};
    hold  = '{A_HOLD,  B_HOLD};
    clrc  = '{A_CLR,   B_CLR};
    free_c   = '{0, 0};
    op_start = '{0, 0};
    op_valid = '{1'b0, 1'b0};

    // reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst ready", ready_a, 1'b1);

    // single write of 0xA5 on default timing
    drive(1'b1, 1'b0, 8'hA5);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("t1 e1 oe", oe_a, 1'b1);
    check("t1 e1 en_n", en_n_a, 1'b1);
    tick();
    check("t1 e2 en_n", en_n_a, 1'b0);
    check("t1 e2 d", bus_d_a, 8'hA5);
    tick();
    check("t1 e3 oe", oe_a, 1'b1);
    check("t1 e3 en_n", en_n_a, 1'b1);
    tick();
    check("t1 e4 done", done_a, 1'b1);
    check("t1 e4 oe", oe_a, 1'b0);
    tick();
    check("t1 e5 done", done_a, 1'b0);

    // zero setup/hold build: strobe in first driven cycle, done next
    drive(1'b1, 1'b0, 8'h7E);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    check("t5 en_n", en_n_b, 1'b0);
    check("t5 oe", oe_b, 1'b1);
    check("t5 d", bus_d_b, 8'h7E);
    tick();
    check("t5 done", done_b, 1'b1);
    check("t5 oe off", oe_b, 1'b0);
    repeat (8) tick();

    // back-to-back pushes until full, then one more on the pop edge
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rec = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 6; i++) begin
      drive(1'b1, 1'b0, vals[k]);
      acc = (ready_a === 1'b1);
      tick();
      if (acc) k++;
    end
    drive(1'b0, 1'b0, 8'h00);
    check("t2 accepted", k, 6);
    repeat (40) tick();
    rec = 1'b0;
    check("t2 strobe count", seen.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < seen.size()) check("t2 strobe order", seen[i], vals[i]);
    end

    // clear between two writes
    drive(1'b1, 1'b0, 8'h12);
    tick();
    drive(1'b1, 1'b1, 8'hFF);
    tick();
    drive(1'b1, 1'b0, 8'h34);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    clr_low = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (clr_n_a === 1'b0) begin
        clr_low++;
        check("t3 oe in clr", oe_a, 1'b0);
        check("t3 en_n in clr", en_n_a, 1'b1);
      end
    end
    check("t3 clr cycles", clr_low, A_CLR);

    // reset while strobing, with a command still queued
    drive(1'b1, 1'b0, 8'h3C);
    tick();
    drive(1'b1, 1'b0, 8'h5A);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (en_n_a === 1'b0) found = 1;
      else tick();
    end
    check("t4 strobe seen", found, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4 en_n", en_n_a, 1'b1);
    check("t4 oe", oe_a, 1'b0);
    check("t4 busy", busy_a, 1'b0);
    check("t4 done", done_a, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t4 no done", done_a, 1'b0);
      check("t4 idle", busy_a, 1'b0);
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_clr   = ($urandom_range(0, 3) == 0);
      cmd_data  = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    repeat (40) tick();
    check("drain busy a", busy_a, 1'b0);
    check("drain busy b", busy_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
